// File: rtl/nios_mtl_timer_ctrl_master_if.sv
// Command/response port and Avalon-MM bus of the timer control master.
// The master modport is the view of nios_mtl_timer_ctrl_master itself; the
// slave modport is the view of whatever sits on the far side (fabric + timer).
interface nios_mtl_timer_ctrl_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_period;
    logic        cmd_continuous;
    logic        cmd_irq_en;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en,
        input  rsp_ready, avm_readdata,
        output cmd_ready, rsp_valid, rsp_data,
        output avm_address, avm_chipselect, avm_write_n, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en,
        output rsp_ready, avm_readdata,
        input  cmd_ready, rsp_valid, rsp_data,
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata
    );
endinterface

// File: rtl/nios_mtl_timer_ctrl_master.sv
// Avalon-MM initiator that expands high-level timer commands (program, stop,
// snapshot, status clear) into register accesses on the interval timer slave,
// returns one 32-bit result per command and counts timer interrupt edges.
module nios_mtl_timer_ctrl_master #(
    parameter int READ_LATENCY = 1,
    parameter int IRQ_CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    nios_mtl_timer_ctrl_master_if.master  bus,
    input  logic                          tmr_irq,
    output logic [IRQ_CNT_W-1:0]          irq_count
);
    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, WR_SNAP, RD_LO, WAIT_LO,
        RD_HI, WAIT_HI, RD_STAT, WAIT_STAT, WR_STAT, RESP
    } state_t;

    localparam logic [1:0] OP_PROGRAM  = 2'd0;
    localparam logic [1:0] OP_STOP     = 2'd1;
    localparam logic [1:0] OP_SNAPSHOT = 2'd2;

    localparam logic [2:0] A_STATUS   = 3'd0;
    localparam logic [2:0] A_CONTROL  = 3'd1;
    localparam logic [2:0] A_PERIOD_L = 3'd2;
    localparam logic [2:0] A_PERIOD_H = 3'd3;
    localparam logic [2:0] A_SNAP_L   = 3'd4;
    localparam logic [2:0] A_SNAP_H   = 3'd5;

    // Last wait-state index: readdata is valid READ_LATENCY cycles after the read phase.
    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

    state_t      state_reg, state_next;
    logic [31:0] period_reg, period_next;
    logic        cont_reg, cont_next;
    logic        ito_reg, ito_next;
    logic        stop_reg, stop_next;
    logic [1:0]  shadow_reg, shadow_next;
    logic [15:0] lo_reg, lo_next;
    logic [31:0] rsp_data_reg, rsp_data_next;
    logic [1:0]  wait_reg, wait_next;
    logic [2:0]  address_reg, address_next;
    logic        chipselect_reg, chipselect_next;
    logic        write_n_reg, write_n_next;
    logic [15:0] writedata_reg, writedata_next;
    logic                 irq_sync_reg;
    logic [IRQ_CNT_W-1:0] irq_count_reg;
    logic                 irq_edge;

    assign bus.cmd_ready      = (state_reg == IDLE);
    assign bus.rsp_valid      = (state_reg == RESP);
    assign bus.rsp_data       = rsp_data_reg;
    assign bus.avm_address    = address_reg;
    assign bus.avm_chipselect = chipselect_reg;
    assign bus.avm_write_n    = write_n_reg;
    assign bus.avm_writedata  = writedata_reg;
    assign irq_count          = irq_count_reg;

    // Next-state, operand/capture updates, and the bus access of the state being entered
    always_comb begin
        state_next    = state_reg;
        period_next   = period_reg;
        cont_next     = cont_reg;
        ito_next      = ito_reg;
        stop_next     = stop_reg;
        shadow_next   = shadow_reg;
        lo_next       = lo_reg;
        rsp_data_next = rsp_data_reg;
        wait_next     = wait_reg;

        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    period_next   = bus.cmd_period;
                    cont_next     = bus.cmd_continuous;
                    ito_next      = bus.cmd_irq_en;
                    stop_next     = (bus.cmd_op == OP_STOP);
                    rsp_data_next = '0;
                    case (bus.cmd_op)
                        OP_PROGRAM:  state_next = WR_PL;
                        OP_STOP:     state_next = WR_CTRL;
                        OP_SNAPSHOT: state_next = WR_SNAP;
                        default:     state_next = RD_STAT;
                    endcase
                end
            end
            WR_PL:   state_next = WR_PH;
            WR_PH:   state_next = WR_CTRL;
            WR_CTRL: begin
                // Only PROGRAM changes the remembered CONT/ITO bits; STOP replays them.
                if (!stop_reg) begin
                    shadow_next = {cont_reg, ito_reg};
                end
                state_next = RESP;
            end
            WR_SNAP: state_next = RD_LO;
            RD_LO: begin
                wait_next  = '0;
                state_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (wait_reg == WAIT_LAST) begin
                    lo_next    = bus.avm_readdata;
                    state_next = RD_HI;
                end else begin
                    wait_next = wait_reg + 2'd1;
                end
            end
            RD_HI: begin
                wait_next  = '0;
                state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (wait_reg == WAIT_LAST) begin
                    rsp_data_next = {bus.avm_readdata, lo_reg};
                    state_next    = RESP;
                end else begin
                    wait_next = wait_reg + 2'd1;
                end
            end
            RD_STAT: begin
                wait_next  = '0;
                state_next = WAIT_STAT;
            end
            WAIT_STAT: begin
                if (wait_reg == WAIT_LAST) begin
                    rsp_data_next = {30'b0, bus.avm_readdata[1:0]};
                    state_next    = WR_STAT;
                end else begin
                    wait_next = wait_reg + 2'd1;
                end
            end
            WR_STAT: state_next = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Bus outputs are registered, so they are derived from the state being entered.
        chipselect_next = 1'b0;
        write_n_next    = 1'b1;
        address_next    = '0;
        writedata_next  = '0;
        case (state_next)
            WR_PL: begin
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
                address_next    = A_PERIOD_L;
                writedata_next  = period_next[15:0];
            end
            WR_PH: begin
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
                address_next    = A_PERIOD_H;
                writedata_next  = period_next[31:16];
            end
            WR_CTRL: begin
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
                address_next    = A_CONTROL;
                writedata_next  = stop_next ? {12'b0, 2'b10, shadow_reg}
                                            : {12'b0, 2'b01, cont_next, ito_next};
            end
            WR_SNAP: begin
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
                address_next    = A_SNAP_L;
            end
            RD_LO: begin
                chipselect_next = 1'b1;
                address_next    = A_SNAP_L;
            end
            RD_HI: begin
                chipselect_next = 1'b1;
                address_next    = A_SNAP_H;
            end
            RD_STAT: begin
                chipselect_next = 1'b1;
                address_next    = A_STATUS;
            end
            WR_STAT: begin
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
                address_next    = A_STATUS;
            end
            default: ;
        endcase
    end

    // State, operand and bus output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            period_reg     <= '0;
            cont_reg       <= 1'b0;
            ito_reg        <= 1'b0;
            stop_reg       <= 1'b0;
            shadow_reg     <= '0;
            lo_reg         <= '0;
            rsp_data_reg   <= '0;
            wait_reg       <= '0;
            address_reg    <= '0;
            chipselect_reg <= 1'b0;
            write_n_reg    <= 1'b1;
            writedata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            period_reg     <= period_next;
            cont_reg       <= cont_next;
            ito_reg        <= ito_next;
            stop_reg       <= stop_next;
            shadow_reg     <= shadow_next;
            lo_reg         <= lo_next;
            rsp_data_reg   <= rsp_data_next;
            wait_reg       <= wait_next;
            address_reg    <= address_next;
            chipselect_reg <= chipselect_next;
            write_n_reg    <= write_n_next;
            writedata_reg  <= writedata_next;
        end
    end

    assign irq_edge = tmr_irq & ~irq_sync_reg;

    // Interrupt rising-edge counter; an edge coinciding with the clear counts as the first event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_sync_reg  <= 1'b0;
            irq_count_reg <= '0;
        end else begin
            irq_sync_reg <= tmr_irq;
            if (state_reg == WR_STAT) begin
                irq_count_reg <= irq_edge ? IRQ_CNT_W'(1) : '0;
            end else if (irq_edge) begin
                irq_count_reg <= irq_count_reg + IRQ_CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_nios_mtl_timer_ctrl_master.sv
// Testbench: two masters (read latency 1 with an interval-timer model, read
// latency 3 with a fixed snapshot slave), table-driven command vectors plus
// hand-written sequences for interrupts, response back-pressure and reset.
module tb_nios_mtl_timer_ctrl_master;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nios_mtl_timer_ctrl_master_if if0 ();
    nios_mtl_timer_ctrl_master_if if1 ();

    logic        tmr_irq0;
    logic [15:0] irq_count0, irq_count1;
    logic        irq_force_en = 1'b0;
    logic        irq_force = 1'b0;
    logic        model_irq;

    nios_mtl_timer_ctrl_master #(.READ_LATENCY(1), .IRQ_CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .bus(if0), .tmr_irq(tmr_irq0), .irq_count(irq_count0));
    nios_mtl_timer_ctrl_master #(.READ_LATENCY(3), .IRQ_CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .bus(if1), .tmr_irq(1'b0), .irq_count(irq_count1));

    // Shared command drive, steered by sel
    int          sel = 0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_period = 32'd0;
    logic        cmd_cont = 1'b0;
    logic        cmd_ito = 1'b0;
    logic        rsp_ready = 1'b0;

    assign if0.cmd_valid = cmd_valid & (sel == 0);
    assign if1.cmd_valid = cmd_valid & (sel == 1);
    assign if0.cmd_op = cmd_op;             assign if1.cmd_op = cmd_op;
    assign if0.cmd_period = cmd_period;     assign if1.cmd_period = cmd_period;
    assign if0.cmd_continuous = cmd_cont;   assign if1.cmd_continuous = cmd_cont;
    assign if0.cmd_irq_en = cmd_ito;        assign if1.cmd_irq_en = cmd_ito;
    assign if0.rsp_ready = rsp_ready & (sel == 0);
    assign if1.rsp_ready = rsp_ready & (sel == 1);
    assign tmr_irq0 = irq_force_en ? irq_force : model_irq;

    logic        m_cmd_ready, m_rsp_valid, m_cs, m_wn;
    logic [31:0] m_rsp_data;
    logic [2:0]  m_addr;
    logic [15:0] m_wd;
    assign m_cmd_ready = (sel == 1) ? if1.cmd_ready      : if0.cmd_ready;
    assign m_rsp_valid = (sel == 1) ? if1.rsp_valid      : if0.rsp_valid;
    assign m_rsp_data  = (sel == 1) ? if1.rsp_data       : if0.rsp_data;
    assign m_cs        = (sel == 1) ? if1.avm_chipselect : if0.avm_chipselect;
    assign m_wn        = (sel == 1) ? if1.avm_write_n    : if0.avm_write_n;
    assign m_addr      = (sel == 1) ? if1.avm_address    : if0.avm_address;
    assign m_wd        = (sel == 1) ? if1.avm_writedata  : if0.avm_writedata;

    // Interval timer model behind u0 (snapshot registers read back fixed words)
    logic [15:0] per_lo, per_hi, rd0;
    logic [31:0] tcnt;
    logic        t_run, t_to, t_cont, t_ito;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_lo <= 16'hFFFF; per_hi <= 16'hFFFF; tcnt <= '0; rd0 <= '0;
            t_run <= 1'b0; t_to <= 1'b0; t_cont <= 1'b0; t_ito <= 1'b0;
        end else begin
            if (t_run) begin
                if (tcnt == 0) begin
                    t_to <= 1'b1;
                    tcnt <= {per_hi, per_lo};
                    if (!t_cont) t_run <= 1'b0;
                end else begin
                    tcnt <= tcnt - 1;
                end
            end
            if (if0.avm_chipselect && !if0.avm_write_n) begin
                case (if0.avm_address)
                    3'd0: if (!(t_run && tcnt == 0)) t_to <= 1'b0;
                    3'd1: begin
                        t_cont <= if0.avm_writedata[1];
                        t_ito  <= if0.avm_writedata[0];
                        if (if0.avm_writedata[2]) begin
                            t_run <= 1'b1;
                            tcnt  <= {per_hi, per_lo};
                        end else if (if0.avm_writedata[3]) begin
                            t_run <= 1'b0;
                        end
                    end
                    3'd2: begin per_lo <= if0.avm_writedata; t_run <= 1'b0; end
                    3'd3: begin per_hi <= if0.avm_writedata; t_run <= 1'b0; end
                    default: ;
                endcase
            end
            if (if0.avm_chipselect && if0.avm_write_n) begin
                case (if0.avm_address)
                    3'd0:    rd0 <= {14'b0, t_run, t_to};
                    3'd1:    rd0 <= {14'b0, t_cont, t_ito};
                    3'd4:    rd0 <= 16'h1234;
                    3'd5:    rd0 <= 16'hABCD;
                    default: rd0 <= 16'h0000;
                endcase
            end
        end
    end
    assign if0.avm_readdata = rd0;
    assign model_irq = t_to & t_ito;

    // Three-cycle read pipeline behind u1
    logic [15:0] p1a, p1b, p1c;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1a <= '0; p1b <= '0; p1c <= '0;
        end else begin
            p1a <= (if1.avm_chipselect && if1.avm_write_n)
                   ? ((if1.avm_address == 3'd4) ? 16'h1234 : (if1.avm_address == 3'd5) ? 16'hABCD : 16'h0000)
                   : 16'h0000;
            p1b <= p1a;
            p1c <= p1b;
        end
    end
    assign if1.avm_readdata = p1c;

    // Bus access log of the selected master
    int          cyc = 0;
    int          log_n = 0;
    logic [19:0] log_acc [512];
    int          log_cyc [512];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (m_cs) begin
            log_acc[log_n % 512] <= {~m_wn, m_addr, m_wd};
            log_cyc[log_n % 512] <= cyc;
            log_n <= log_n + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        int               dut;
        logic [1:0]       op;
        logic [31:0]      period;
        logic             cont;
        logic             ito;
        logic [31:0]      exp_rsp;
        int               exp_n;
        logic [3:0][27:0] acc;   // {is_write, addr, wdata, cycle offset}
    } vec_t;

    vec_t vecs [10];
    int   nvec = 0;

    function automatic logic [27:0] mk(input logic we, input logic [2:0] a, input logic [15:0] d, input logic [7:0] off);
        return {we, a, d, off};
    endfunction

    task automatic add(input int d, input logic [1:0] op, input logic [31:0] per, input logic c, input logic i,
                       input logic [31:0] rsp, input int n,
                       input logic [27:0] a0, input logic [27:0] a1, input logic [27:0] a2, input logic [27:0] a3);
        vecs[nvec].dut = d;      vecs[nvec].op = op;       vecs[nvec].period = per;
        vecs[nvec].cont = c;     vecs[nvec].ito = i;       vecs[nvec].exp_rsp = rsp;
        vecs[nvec].exp_n = n;
        vecs[nvec].acc[0] = a0;  vecs[nvec].acc[1] = a1;
        vecs[nvec].acc[2] = a2;  vecs[nvec].acc[3] = a3;
        nvec++;
    endtask

    // Issue one command from a negedge with the master idle, wait for and accept the response
    task automatic run_cmd(input int d, input logic [1:0] op, input logic [31:0] per, input logic c, input logic i,
                           output logic [31:0] data, output logic [15:0] cnt, output bit ok);
        sel = d; cmd_op = op; cmd_period = per; cmd_cont = c; cmd_ito = i;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        data = m_rsp_data;
        cnt = (d == 1) ? irq_count1 : irq_count0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    bit          ok;
    logic [31:0] got;
    logic [15:0] gcnt;
    int          base, got_n, idx;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        add(0, 2'd0, 32'h0001_86A0, 1, 1, 32'h0, 3, mk(1,2,16'h86A0,0), mk(1,3,16'h0001,1), mk(1,1,16'h0007,2), 28'h0);
        add(0, 2'd3, 32'h0,         0, 0, 32'h2, 2, mk(0,0,16'h0,0),    mk(1,0,16'h0000,2), 28'h0, 28'h0);
        add(0, 2'd2, 32'h0,         0, 0, 32'hABCD1234, 3, mk(1,4,16'h0,0), mk(0,4,16'h0,1), mk(0,5,16'h0,3), 28'h0);
        add(0, 2'd0, 32'h0000_1000, 1, 0, 32'h0, 3, mk(1,2,16'h1000,0), mk(1,3,16'h0000,1), mk(1,1,16'h0006,2), 28'h0);
        add(0, 2'd1, 32'h0,         0, 0, 32'h0, 1, mk(1,1,16'h000A,0), 28'h0, 28'h0, 28'h0);
        add(0, 2'd3, 32'h0,         0, 0, 32'h0, 2, mk(0,0,16'h0,0),    mk(1,0,16'h0000,2), 28'h0, 28'h0);
        add(1, 2'd2, 32'h0,         0, 0, 32'hABCD1234, 3, mk(1,4,16'h0,0), mk(0,4,16'h0,1), mk(0,5,16'h0,5), 28'h0);
        add(0, 2'd0, 32'h0000_0009, 1, 1, 32'h0, 3, mk(1,2,16'h0009,0), mk(1,3,16'h0000,1), mk(1,1,16'h0007,2), 28'h0);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", if0.cmd_ready, 1);
        chk("rst_rsp_valid", if0.rsp_valid, 0);
        chk("rst_rsp_data", if0.rsp_data, 0);
        chk("rst_cs", if0.avm_chipselect, 0);
        chk("rst_write_n", if0.avm_write_n, 1);
        chk("rst_addr", if0.avm_address, 0);
        chk("rst_wdata", if0.avm_writedata, 0);
        chk("rst_irq_count", irq_count0, 0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven commands
        for (int r = 0; r < nvec; r++) begin
            base = log_n;
            run_cmd(vecs[r].dut, vecs[r].op, vecs[r].period, vecs[r].cont, vecs[r].ito, got, gcnt, ok);
            got_n = log_n - base;
            $display("[TB] vec %0d dut %0d op %0d rsp 0x%08h accesses %0d", r, vecs[r].dut, vecs[r].op, got, got_n);
            chk("vec_rsp_timeout", ok, 1);
            chk("vec_rsp_data", got, vecs[r].exp_rsp);
            chk("vec_access_count", got_n, vecs[r].exp_n);
            for (int k = 0; k < vecs[r].exp_n; k++) begin
                if (k < got_n) begin
                    idx = (base + k) % 512;
                    chk("vec_access_kind_addr", log_acc[idx][19:16], vecs[r].acc[k][27:24]);
                    if (vecs[r].acc[k][27]) chk("vec_access_wdata", log_acc[idx][15:0], vecs[r].acc[k][23:8]);
                    chk("vec_access_cycle", log_cyc[idx] - log_cyc[base % 512], vecs[r].acc[k][7:0]);
                end
            end
        end

        // Period-9 timer: three interrupts, each cleared by STATUS_CLEAR
        for (int it = 0; it < 3; it++) begin
            ok = 1'b0;
            for (int k = 0; k < 60; k++) begin
                if (irq_count0 == 16'd1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            chk("irq_wait", ok, 1);
            chk("irq_count_before_clear", irq_count0, 1);
            run_cmd(0, 2'd3, 32'h0, 0, 0, got, gcnt, ok);
            $display("[TB] irq %0d status 0x%08h count_after %0d", it, got, gcnt);
            chk("irq_rsp_timeout", ok, 1);
            chk("irq_status", got, 32'h3);
            chk("irq_count_after_clear", gcnt, 0);
        end

        // Response back-pressure: hold rsp_ready low for 5 cycles
        sel = 0; cmd_op = 2'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("hold_rsp_timeout", ok, 1);
        base = log_n;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", m_rsp_valid, 1);
            chk("hold_rsp_data", m_rsp_data, 32'hABCD1234);
            chk("hold_cmd_ready", m_cmd_ready, 0);
            chk("hold_bus_idle", log_n - base, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        $display("[TB] hold snapshot released cmd_ready %0d rsp_valid %0d", m_cmd_ready, m_rsp_valid);
        chk("release_cmd_ready", m_cmd_ready, 1);
        chk("release_rsp_valid", m_rsp_valid, 0);

        // Interrupt edge in the same cycle as the counter clear
        irq_force_en = 1'b1; irq_force = 1'b0;
        repeat (2) @(negedge clk);
        cmd_op = 2'd3; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (if0.avm_chipselect && !if0.avm_write_n && if0.avm_address == 3'd0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("edge_find_wr_stat", ok, 1);
        irq_force = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (m_rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("edge_rsp_timeout", ok, 1);
        $display("[TB] edge+clear irq_count %0d", irq_count0);
        chk("edge_and_clear_count", irq_count0, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset asserted while the period high half is being written
        cmd_op = 2'd0; cmd_period = 32'h0005_0004; cmd_cont = 1'b1; cmd_ito = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (if0.avm_chipselect && !if0.avm_write_n && if0.avm_address == 3'd3) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("reset_find_wr_ph", ok, 1);
        chk("reset_pre_count", irq_count0, 1);
        reset = 1'b1;
        #1;
        chk("reset_cs", if0.avm_chipselect, 0);
        chk("reset_rsp_valid", if0.rsp_valid, 0);
        chk("reset_irq_count", irq_count0, 0);
        chk("reset_cmd_ready", if0.cmd_ready, 1);
        @(negedge clk);
        chk("reset_next_cs", if0.avm_chipselect, 0);
        chk("reset_next_cmd_ready", if0.cmd_ready, 1);
        $display("[TB] reset during WR_PH cs %0d cmd_ready %0d", if0.avm_chipselect, if0.cmd_ready);
        reset = 1'b0;
        irq_force_en = 1'b0;
        @(negedge clk);

        // Master is usable again after the abort
        run_cmd(0, 2'd3, 32'h0, 0, 0, got, gcnt, ok);
        $display("[TB] post-reset status 0x%08h count %0d", got, gcnt);
        chk("post_reset_timeout", ok, 1);
        chk("post_reset_status", got, 32'h0);
        chk("post_reset_count", gcnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
